// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage access controller: bus widths, access
// opcodes, controller states and the alignment rule.
package mem_access_ctrl_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  mask_t;

  typedef enum logic [2:0] {
    MEM_NO,
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_D,
    MEM_BU,
    MEM_HU,
    MEM_WU
  } mem_op_enum;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam int CNT_W = 16;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_H, MEM_HU: mis = off[0];
      MEM_W, MEM_WU: mis = |off[1:0];
      MEM_D:         mis = |off;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory handshake bundle between the access controller and memory.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic  dmem_req;
  logic  dmem_we;
  addr_t dmem_addr;
  data_t dmem_wdata;
  mask_t dmem_wmask;
  logic  dmem_ack;
  data_t dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_load_data_ext.sv
// Aligns a captured 64-bit memory word to the addressed byte and extends
// the selected field to 64 bits according to the load opcode.
module load_data_ext
  import mem_access_ctrl_pkg::*;
(
  input  data_t      raw,
  input  logic [2:0] byte_off,
  input  mem_op_enum op,
  output data_t      ext
);

  data_t shifted;

  // Shift the addressed byte down to bit 0, then truncate and extend.
  always_comb begin
    shifted = raw >> {byte_off, 3'b000};
    ext     = shifted;
    case (op)
      MEM_B:   ext = {{56{shifted[7]}},  shifted[7:0]};
      MEM_BU:  ext = {56'b0,             shifted[7:0]};
      MEM_H:   ext = {{48{shifted[15]}}, shifted[15:0]};
      MEM_HU:  ext = {48'b0,             shifted[15:0]};
      MEM_W:   ext = {{32{shifted[31]}}, shifted[31:0]};
      MEM_WU:  ext = {32'b0,             shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: checks alignment, drives one data-memory
// transaction per request with a bounded wait for ack, and returns the
// extended load result with a single-cycle done pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic       req_we,
  input  mem_op_enum mem_op,
  input  addr_t      req_addr,
  input  data_t      req_wdata,
  input  mask_t      req_wmask,
  output logic       stall,
  output logic       done,
  output logic       err,
  output data_t      rdata_ext,
  mem_access_ctrl_if.master dmem
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  mem_op_enum       op_q, op_d;
  addr_t            addr_q, addr_d;
  data_t            wdata_q, wdata_d;
  mask_t            wmask_q, wmask_d;
  data_t            rdata_q, rdata_d;

  data_t            ld_ext;
  logic             in_access;
  logic             in_done;

  load_data_ext u_load_data_ext (
    .raw      (rdata_q),
    .byte_off (addr_q[2:0]),
    .op       (op_q),
    .ext      (ld_ext)
  );

  // Next-state logic: accept/reject in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (mem_op != MEM_NO)) begin
          if (is_misaligned(mem_op, req_addr[2:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            we_d    = req_we;
            op_d    = mem_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wmask_d = req_wmask;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem.dmem_ack) begin
          rdata_d = dmem.dmem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Latched request and captured read data; only observed through gated outputs.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
    rdata_q <= rdata_d;
  end

  // Outputs are forced to zero outside their valid state and while reset is held.
  always_comb begin
    in_access        = rstn && (state_q == ACCESS);
    in_done          = rstn && (state_q == DONE);
    dmem.dmem_req    = in_access;
    dmem.dmem_we     = in_access ? we_q : 1'b0;
    dmem.dmem_addr   = in_access ? addr_q : '0;
    dmem.dmem_wdata  = in_access ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
    dmem.dmem_wmask  = in_access ? wmask_q : '0;
    done             = in_done;
    err              = in_done && err_q;
    rdata_ext        = (in_done && !err_q && !we_q) ? ld_ext : '0;
    stall            = req_valid && !in_done;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a transaction-level reference
// model and a per-cycle compare process.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TMO = 4;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic       req_we;
  mem_op_enum mem_op;
  addr_t      req_addr;
  data_t      req_wdata;
  mask_t      req_wmask;
  logic       stall;
  logic       done;
  logic       err;
  data_t      rdata_ext;

  mem_access_ctrl_if dmem_if ();

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .mem_op    (mem_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata_ext (rdata_ext),
    .dmem      (dmem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, written by the stimulus.
  logic        exp_req, exp_done, exp_err, exp_rst, exp_we;
  logic [63:0] exp_rdata, exp_addr, exp_wdata;
  logic [7:0]  exp_wmask;
  int          pin_mode = 0;
  int          start_cyc = 0;
  int          ack_cyc = 0;

  // Counters and observations owned by the compare process.
  int          total = 0;
  int          bad = 0;
  int          req_cnt = 0;
  int          last_done_cyc = 0;
  logic        prev_req = 1'b0;
  logic [63:0] last_wdata = '0;

  function automatic int op_size(input mem_op_enum op);
    case (op)
      MEM_H, MEM_HU: return 2;
      MEM_W, MEM_WU: return 4;
      MEM_D:         return 8;
      default:       return 1;
    endcase
  endfunction

  function automatic bit op_signed(input mem_op_enum op);
    return (op == MEM_B) || (op == MEM_H) || (op == MEM_W);
  endfunction

  function automatic bit misaligned_ref(input mem_op_enum op, input logic [63:0] addr);
    return (addr % 64'(op_size(op))) != 0;
  endfunction

  // Byte-wise gather of the addressed field, then fill upper bytes by sign.
  function automatic logic [63:0] ref_load(input mem_op_enum op, input logic [63:0] addr,
                                           input logic [63:0] d);
    logic [63:0] r;
    int          nb;
    int          off;
    nb  = op_size(op);
    off = int'(addr % 64'd8);
    r   = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*((off + i) % 8) +: 8];
    if (op_signed(op) && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Single compare process: every cycle against the model, plus literal pins.
  always @(negedge clk) begin
    chk("stall", 64'(stall), 64'(req_valid && !exp_done));
    chk("dmem_req", 64'(dmem_if.dmem_req), 64'(exp_req));
    chk("done", 64'(done), 64'(exp_done));
    if (exp_rst) begin
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdata", rdata_ext, 64'd0);
      chk("rst_addr", dmem_if.dmem_addr, 64'd0);
      chk("rst_wdata", dmem_if.dmem_wdata, 64'd0);
      chk("rst_wmask", 64'(dmem_if.dmem_wmask), 64'd0);
      req_cnt = 0;
    end
    if (exp_req) begin
      chk("dmem_addr", dmem_if.dmem_addr, exp_addr);
      chk("dmem_we", 64'(dmem_if.dmem_we), 64'(exp_we));
      chk("dmem_wdata", dmem_if.dmem_wdata, exp_wdata);
      chk("dmem_wmask", 64'(dmem_if.dmem_wmask), 64'(exp_wmask));
      last_wdata = dmem_if.dmem_wdata;
    end
    if (dmem_if.dmem_req) begin
      if (!prev_req && pin_mode == 7)
        chk("b2b_req_gap", 64'(cyc - last_done_cyc), 64'd2);
      req_cnt++;
    end
    if (exp_done) begin
      chk("err", 64'(err), 64'(exp_err));
      chk("rdata_ext", rdata_ext, exp_rdata);
      case (pin_mode)
        1: begin
          chk("sw_wdata", last_wdata, 64'hDEADBEEF00000000);
          chk("sw_ack_to_done", 64'(cyc - ack_cyc), 64'd1);
          chk("sw_err", 64'(err), 64'd0);
        end
        2: chk("lb_rdata", rdata_ext, 64'hFFFFFFFFFFFFFF80);
        3: chk("lbu_rdata", rdata_ext, 64'h0000000000000080);
        4: begin
          chk("ld_mis_err", 64'(err), 64'd1);
          chk("ld_mis_reqs", 64'(req_cnt), 64'd0);
          chk("ld_mis_latency", 64'(cyc - start_cyc), 64'd1);
        end
        5: begin
          chk("tmo_err", 64'(err), 64'd1);
          chk("tmo_rdata", rdata_ext, 64'd0);
          chk("tmo_access_cycles", 64'(req_cnt), 64'd4);
        end
        6: begin
          chk("ack_at_tmo_err", 64'(err), 64'd0);
          chk("ack_at_tmo_cycles", 64'(req_cnt), 64'd4);
        end
        default: ;
      endcase
      last_done_cyc = cyc;
      req_cnt = 0;
    end
    prev_req = dmem_if.dmem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;
    exp_we = 1'b0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
  endtask

  task automatic junk_ack();
    dmem_if.dmem_ack   = 1'($urandom_range(0, 1));
    dmem_if.dmem_rdata = {$urandom, $urandom};
  endtask

  // One MEM-stage request from presentation in IDLE through the done cycle.
  task automatic run_txn(input bit we, input mem_op_enum op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask,
                         input int ack_at, input logic [63:0] rd);
    bit mis;
    bit tmo;
    int n;
    mis = misaligned_ref(op, addr);
    tmo = !(ack_at >= 1 && ack_at <= TMO);
    n   = tmo ? TMO : ack_at;
    req_valid = 1'b1; req_we = we; mem_op = op;
    req_addr = addr; req_wdata = wdata; req_wmask = mask;
    start_cyc = cyc;
    exp_idle();
    junk_ack();
    step();
    if (!mis) begin
      for (int c = 1; c <= n; c++) begin
        exp_idle();
        exp_req = 1'b1; exp_addr = addr; exp_we = we; exp_wmask = mask;
        exp_wdata = wdata << (8 * (addr % 64'd8));
        req_we = 1'($urandom_range(0, 1));
        mem_op = mem_op_enum'(3'($urandom_range(0, 7)));
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
        if (c == ack_at) begin
          dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = rd; ack_cyc = cyc;
        end else begin
          dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = {$urandom, $urandom};
        end
        step();
      end
    end
    exp_idle();
    exp_done  = 1'b1;
    exp_err   = mis || tmo;
    exp_rdata = (mis || tmo || we) ? 64'd0 : ref_load(op, addr, rd);
    junk_ack();
    step();
  endtask

  task automatic gap_cycle();
    req_valid = 1'b0;
    exp_idle();
    junk_ack();
    step();
  endtask

  task automatic no_op_cycle();
    req_valid = 1'b1;
    mem_op = MEM_NO;
    req_addr = {$urandom, $urandom};
    exp_idle();
    junk_ack();
    step();
  endtask

  // Aligned load abandoned by a one-cycle reset, followed by stale acks.
  task automatic reset_mid_access();
    req_valid = 1'b1; req_we = 1'b0; mem_op = MEM_W;
    req_addr = 64'h40; req_wdata = '0; req_wmask = 8'h0F;
    exp_idle();
    dmem_if.dmem_ack = 1'b0;
    step();
    for (int c = 1; c <= 2; c++) begin
      exp_idle();
      exp_req = 1'b1; exp_addr = 64'h40; exp_we = 1'b0; exp_wdata = '0; exp_wmask = 8'h0F;
      dmem_if.dmem_ack = 1'b0;
      step();
    end
    rstn = 1'b0; req_valid = 1'b0;
    exp_idle(); exp_rst = 1'b1;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_idle();
      dmem_if.dmem_ack = 1'b1;
      dmem_if.dmem_rdata = 64'h1122334455667788;
      step();
    end
    dmem_if.dmem_ack = 1'b0;
  endtask

  initial begin
    bit          we;
    mem_op_enum  op;
    logic [63:0] addr;
    int          r;
    int          sz;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; mem_op = MEM_NO;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    exp_idle(); exp_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_idle(); exp_rst = 1'b1;
      step();
    end
    rstn = 1'b1;
    gap_cycle();

    pin_mode = 1;
    run_txn(1'b1, MEM_W, 64'h1004, 64'hDEADBEEF, 8'hF0, 3, 64'd0);
    pin_mode = 0; gap_cycle();

    pin_mode = 2;
    run_txn(1'b0, MEM_B, 64'h2003, 64'd0, 8'h08, 2, 64'h0000000080000000);
    pin_mode = 3;
    run_txn(1'b0, MEM_BU, 64'h2003, 64'd0, 8'h08, 2, 64'h0000000080000000);
    pin_mode = 0; gap_cycle();

    pin_mode = 4;
    run_txn(1'b0, MEM_D, 64'h3004, 64'd0, 8'hFF, 1, 64'hFFFF0000FFFF0000);
    pin_mode = 0; gap_cycle();

    pin_mode = 5;
    run_txn(1'b0, MEM_W, 64'h4000, 64'd0, 8'h0F, 0, 64'h0123456789ABCDEF);
    pin_mode = 0; gap_cycle();
    pin_mode = 6;
    run_txn(1'b0, MEM_W, 64'h4000, 64'd0, 8'h0F, 4, 64'h0123456789ABCDEF);
    pin_mode = 0; gap_cycle();

    reset_mid_access();
    run_txn(1'b0, MEM_H, 64'h5006, 64'd0, 8'hC0, 1, 64'h8001000000000000);
    gap_cycle();

    run_txn(1'b0, MEM_W, 64'h100, 64'd0, 8'h0F, 2, 64'h00000000CAFEF00D);
    pin_mode = 7;
    run_txn(1'b0, MEM_D, 64'h208, 64'd0, 8'hFF, 1, 64'h8877665544332211);
    pin_mode = 0; gap_cycle();

    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        no_op_cycle();
      end else begin
        op   = mem_op_enum'(3'(r));
        we   = 1'($urandom_range(0, 1));
        addr = {$urandom, $urandom};
        sz   = op_size(op);
        if ($urandom_range(0, 3) != 0)
          addr[2:0] = 3'(sz * int'($urandom_range(0, 8 / sz - 1)));
        run_txn(we, op, addr, {$urandom, $urandom}, 8'($urandom),
                int'($urandom_range(0, 6)), {$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) gap_cycle();
      end
    end
    gap_cycle();
    gap_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for dmem_ack before aborting.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1, the MEM stage holds a memory access.
REQ-005 The block SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-006 The block SHALL have port mem_op, input, mem_op_enum, access width and signedness.
REQ-007 The block SHALL have port req_addr, input, addr_t (64), the byte address.
REQ-008 The block SHALL have port req_wdata, input, data_t (64), store data, LSB-justified.
REQ-009 The block SHALL have port req_wmask, input, mask_t (8), byte mask from the write-mask generator.
REQ-010 The block SHALL have port stall, output, 1, the pipeline holds the MEM stage.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1, valid with done: misaligned access or timeout.
REQ-013 The block SHALL have port rdata_ext, output, data_t, load result extended to 64 bits, valid with done.
REQ-014 The block SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, addr_t), dmem_wdata (output, data_t), dmem_wmask (output, mask_t), dmem_ack (input, 1) and dmem_rdata (input, data_t), forming the data-memory handshake.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-016 IDLE with req_valid=1 and an aligned access SHALL latch we, op, addr, wdata and mask, then go to ACCESS.
REQ-017 IDLE with req_valid=1 and a misaligned access SHALL go to DONE with err=1, without asserting dmem_req.
REQ-018 Misaligned SHALL mean D with addr[2:0]≠0, W/UW with addr[1:0]≠0, or H/UH with addr[0]≠0. B/UB is never misaligned.
REQ-019 IDLE with mem_op=MEM_NO SHALL be treated as no request.
REQ-020 In ACCESS, dmem_req SHALL be 1 and dmem_addr, dmem_we and dmem_wmask SHALL be the latched values, stable until ack.
REQ-021 In ACCESS, dmem_wdata SHALL equal the latched wdata shifted left by 8·addr[2:0] bits.
REQ-022 A dmem_ack sampled high in ACCESS SHALL capture dmem_rdata and move to DONE. dmem_req SHALL drop in the next cycle.
REQ-023 A 16-bit counter SHALL clear on entry to ACCESS and increment each cycle without ack.
REQ-024 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to DONE with err=1 and rdata_ext=0.
REQ-025 An ack in the same cycle as the timeout SHALL win, giving err=0.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 A new request SHALL be accepted no earlier than the cycle after DONE, so there is one bubble.
REQ-028 stall SHALL equal req_valid AND NOT done, and be combinational.
REQ-029 For loads, rdata_ext SHALL be the captured data shifted right by 8·addr[2:0], truncated to the op width, then extended.
REQ-030 Extension SHALL be sign extension for B/H/W, zero extension for UB/UH/UW, and none for D.
REQ-031 For stores, rdata_ext SHALL be 0.
REQ-032 dmem_ack outside ACCESS SHALL be ignored.

Reset
REQ-033 With rstn=0 at a clock edge, the FSM SHALL go to IDLE and the counter to 0.
REQ-034 During reset, dmem_req, done, err and rdata_ext SHALL be 0, and dmem_addr, dmem_wdata and dmem_wmask SHALL be 0.
REQ-035 Reset during ACCESS SHALL abandon the transaction with no done pulse. A later stale ack SHALL be ignored.

Structure
REQ-036 The FSM state enum and the misalignment helper function SHALL live in CorePack. addr_t, data_t, mask_t and mem_op_enum SHALL be reused from CorePack.
REQ-037 Load shifting and extension SHALL be a combinational sub-module, load_data_ext.
REQ-038 Target size SHALL be 150–300 lines of RTL.

Verification
REQ-039 The bench SHALL cover: SW store, addr=0x1004, wdata=0xDEADBEEF, mask=0xF0, ack after 3 cycles → dmem_wdata=0xDEADBEEF00000000, done one cycle after ack, err=0.
REQ-040 The bench SHALL cover: LB load, addr=0x2003, dmem_rdata=0x0000_0000_8000_0000 → rdata_ext=0xFFFF_FFFF_FFFF_FF80. The same data with LBU → 0x80.
REQ-041 The bench SHALL cover: LD load, addr=0x3004 → done with err=1 the next cycle, dmem_req never asserted.
REQ-042 The bench SHALL cover: TIMEOUT=4 with no ack → done with err=1 after 4 ACCESS cycles, rdata_ext=0. The same run with ack on the 4th cycle → err=0.
REQ-043 The bench SHALL cover: rstn low for one cycle mid-ACCESS, then ack → no done pulse, dmem_req=0, FSM in IDLE.
REQ-044 The bench SHALL cover: back-to-back loads with req_valid held → stall high except during the done cycle, second dmem_req rising two cycles after the first done.
